// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM state type for the BCD adder
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_CORR    = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - combinational single-digit BCD add with >9 detect and +6 correction
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] w_s;
    logic                 w_corr;

    // Raw 5-bit sum, then correct when it overflowed 4 bits or exceeds 9
    always_comb begin
        w_s    = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        w_corr = w_s[4] | (w_s[3] & (w_s[2] | w_s[1]));
        digit  = w_corr ? (w_s[BCD_DIGIT_W-1:0] + BCD_CORR) : w_s[BCD_DIGIT_W-1:0];
        cout   = w_corr;
    end

endmodule

// File: rtl/bcd_add_seq.sv
// rtl/bcd_add_seq.sv - digit-serial BCD adder controller; optional input check under BCD_ADD_SEQ_ERRCHK_EN
module bcd_add_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          err
);

    localparam int               W        = BCD_DIGIT_W * DIGITS;
    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                 r_state;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic [W-1:0]           r_sum;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_busy;
    logic                   r_done;

    logic [BCD_DIGIT_W-1:0] w_dig_a;
    logic [BCD_DIGIT_W-1:0] w_dig_b;
    logic [BCD_DIGIT_W-1:0] w_dig_sum;
    logic                   w_dig_cout;

    // Select the digit currently being processed from the latched operands
    always_comb begin
        w_dig_a = r_a[r_idx * BCD_DIGIT_W +: BCD_DIGIT_W];
        w_dig_b = r_b[r_idx * BCD_DIGIT_W +: BCD_DIGIT_W];
    end

    bcd_digit_cell u_cell (
        .a     (w_dig_a),
        .b     (w_dig_b),
        .cin   (r_carry),
        .digit (w_dig_sum),
        .cout  (w_dig_cout)
    );

    // Controller: latch on start, one digit per cycle, single-cycle done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_sum[r_idx * BCD_DIGIT_W +: BCD_DIGIT_W] <= w_dig_sum;
                    r_carry <= w_dig_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_dig_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef BCD_ADD_SEQ_ERRCHK_EN
    logic w_nonbcd;
    logic r_err;

    // Flag any operand digit above 9 at the moment a start is accepted
    always_comb begin
        w_nonbcd = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i * BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) w_nonbcd = 1'b1;
            if (b[i * BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) w_nonbcd = 1'b1;
        end
    end

    // Error flag is refreshed only on an accepted start and otherwise holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_err <= w_nonbcd;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bcd_add_seq.sv
// tb/tb_bcd_add_seq.sv - scoreboard bench for bcd_add_seq
module tb_bcd_add_seq;

    localparam int DIGITS = 4;
`ifdef BCD_ADD_SEQ_ERRCHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    bcd_add_seq #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_dec(input logic [15:0] x);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
        int          t = to_dec(x) + to_dec(y);
        logic [15:0] r = '0;
        logic        c = (t >= 10000);
        t = t % 10000;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {c, r};
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Launch one addition, then watch outputs until the done pulse and compare to the scoreboard
    task automatic do_add(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [15:0] xs, input logic xc, input logic xe,
                          input logic inject);
        exp_t e;
        int   lat = 0;
        int   busy_cnt = 0;
        int   ndone = 0;
        e.s = xs; e.c = xc; e.e = xe;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        while (lat < 20 && ndone == 0) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 2) begin
                a = 16'h1111; b = 16'h2222; start = 1'b1;
            end
            if (inject && lat == 4) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                ndone++;
                if (q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sum", {16'h0, sum}, {16'h0, e.s});
                    check("cout", {31'h0, cout}, {31'h0, e.c});
                    check("err", {31'h0, err}, {31'h0, e.e});
                end
            end
        end
        check("done_latency", lat, 5);
        @(negedge clk);
        check("done_one_cycle", {31'h0, done}, 32'd0);
        check("busy_cycles", busy_cnt, 5);
        check("busy_low", {31'h0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("done_count", ndone, 1);
    endtask

    task automatic add_model(input logic [15:0] ta, input logic [15:0] tb_v, input logic inject);
        logic [16:0] m = model(ta, tb_v);
        do_add(ta, tb_v, m[15:0], m[16], 1'b0, inject);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_sum", {16'h0, sum}, 32'd0);
        check("rst_cout", {31'h0, cout}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_add(16'h0123, 16'h0456, 16'h0579, 1'b0, 1'b0, 1'b0);
        do_add(16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0);
        do_add(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_add(16'h5555, 16'h5555, 16'h1110, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add_model(rand_bcd(), rand_bcd(), 1'b0);

        // Start pulses during ADD must be ignored
        add_model(16'h4821, 16'h3719, 1'b1);

        // Asynchronous reset in the middle of an addition
        do_add(16'h0777, 16'h0777, 16'h1554, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_done", {31'h0, done}, 32'd0);
        check("mid_rst_sum", {16'h0, sum}, 32'd0);
        check("mid_rst_cout", {31'h0, cout}, 32'd0);
        check("mid_rst_err", {31'h0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        add_model(16'h2468, 16'h1357, 1'b0);

        // Non-BCD operand digit, then a clean start clears the flag
        do_add(16'h000A, 16'h0000, 16'h0010, 1'b0, ERR_ON, 1'b0);
        check("err_hold", {31'h0, err}, {31'h0, ERR_ON});
        add_model(16'h0001, 16'h0002, 1'b0);

        check("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
